uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with a built-in transmit FIFO. It replaces the parity, frame, baud and shift-register chain with a single synchronous block. Bytes are pushed into the FIFO through a send/ready handshake, then serialised LSB-first as start, data (5-8 bits), optional parity, and 1 or 2 stop bits. Frame timing comes from a per-bit divisor selected by baud_rate.

---
 rtl/uart_tx_fifo.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated circular transmit FIFO.
// Frames are start, 5-8 data bits LSB first, optional parity, then 1 or 2 stop bits.
// Frame configuration and bit divisor are latched when a byte leaves the FIFO.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DIV_0 = 5208,
  parameter int unsigned DIV_1 = 2604,
  parameter int unsigned DIV_2 = 1302,
  parameter int unsigned DIV_3 = 434,
  parameter int unsigned DIV_W = 16
) (
  input  logic                         clock,
  input  logic                         rst,
  input  logic                         send,
  input  logic [7:0]                   data_in,
  output logic                         ready,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  input  logic [1:0]                   baud_rate,
  input  logic [1:0]                   parity_type,
  input  logic                         stop_bits,
  input  logic [1:0]                   data_length,
  output logic                         data_out,
  output logic                         tx_active,
  output logic                         tx_done
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic [7:0]       mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    count_q;
  logic             full, push, pop;

  state_e           state_q;
  logic [DIV_W-1:0] baud_cnt_q, div_q, div_sel;
  logic [7:0]       byte_q;
  logic [1:0]       parity_q, len_q;
  logic             stop2_q, stop_idx_q;
  logic [2:0]       bit_idx_q, last_idx;
  logic             bit_end, parity_en, parity_bit;
  logic [7:0]       masked;

  assign full       = (count_q == LW'(DEPTH));
  assign ready      = !full;
  assign fifo_level = count_q;
  // A full FIFO refuses a push even if a pop happens on the same edge.
  assign push       = send && !full;
  assign pop        = (state_q == StIdle) && (count_q != '0);

  // Divisor select, data-length decode and parity over the latched frame.
  always_comb begin
    div_sel = DIV_W'(DIV_0);
    unique case (baud_rate)
      2'b00:   div_sel = DIV_W'(DIV_0);
      2'b01:   div_sel = DIV_W'(DIV_1);
      2'b10:   div_sel = DIV_W'(DIV_2);
      default: div_sel = DIV_W'(DIV_3);
    endcase
    last_idx   = {1'b0, len_q} + 3'd4;
    masked     = byte_q & (8'hFF >> (2'd3 - len_q));
    parity_en  = (parity_q == 2'b01) || (parity_q == 2'b10);
    parity_bit = (parity_q == 2'b01) ? ~^masked : ^masked;
    bit_end    = (baud_cnt_q == div_q - DIV_W'(1));
  end

  // FIFO storage; entries need no reset since the level gates every read.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= data_in;
  end

  // FIFO pointers, occupancy and the registered overflow pulse.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= send && full;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + LW'(1);
      else if (pop && !push) count_q <= count_q - LW'(1);
    end
  end

  // Transmit FSM with bit timer and registered line outputs.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      div_q      <= DIV_W'(DIV_0);
      byte_q     <= '0;
      parity_q   <= '0;
      len_q      <= '0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      bit_idx_q  <= '0;
      data_out   <= 1'b1;
      tx_active  <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state_q != StIdle) baud_cnt_q <= bit_end ? '0 : baud_cnt_q + DIV_W'(1);
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            byte_q     <= mem[rd_ptr_q];
            div_q      <= div_sel;
            parity_q   <= parity_type;
            stop2_q    <= stop_bits;
            len_q      <= data_length;
            baud_cnt_q <= '0;
            data_out   <= 1'b0;
            tx_active  <= 1'b1;
            state_q    <= StStart;
          end
        end
        StStart: begin
          if (bit_end) begin
            bit_idx_q <= '0;
            data_out  <= byte_q[0];
            state_q   <= StData;
          end
        end
        StData: begin
          if (bit_end) begin
            if (bit_idx_q == last_idx) begin
              if (parity_en) begin
                data_out <= parity_bit;
                state_q  <= StParity;
              end else begin
                data_out   <= 1'b1;
                stop_idx_q <= 1'b0;
                state_q    <= StStop;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              data_out  <= byte_q[bit_idx_q + 3'd1];
            end
          end
        end
        StParity: begin
          if (bit_end) begin
            data_out   <= 1'b1;
            stop_idx_q <= 1'b0;
            state_q    <= StStop;
          end
        end
        StStop: begin
          if (bit_end) begin
            if (stop_idx_q == stop2_q) begin
              tx_done   <= 1'b1;
              tx_active <= 1'b0;
              state_q   <= StIdle;
            end else begin
              stop_idx_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with small divisors; line patterns are hand-derived strings.
module tb_uart_tx_fifo;

  logic       clock, rst, send, ready, overflow, stop_bits, data_out, tx_active, tx_done;
  logic [7:0] data_in;
  logic [2:0] fifo_level;
  logic [1:0] baud_rate, parity_type, data_length;

  int total = 0;
  int bad   = 0;

  uart_tx_fifo #(
    .DEPTH(4), .DIV_0(4), .DIV_1(6), .DIV_2(8), .DIV_3(10), .DIV_W(16)
  ) dut (
    .clock(clock), .rst(rst), .send(send), .data_in(data_in), .ready(ready),
    .overflow(overflow), .fifo_level(fifo_level), .baud_rate(baud_rate),
    .parity_type(parity_type), .stop_bits(stop_bits), .data_length(data_length),
    .data_out(data_out), .tx_active(tx_active), .tx_done(tx_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    send    = 1'b1;
    data_in = b;
    @(negedge clock);
    send    = 1'b0;
  endtask

  // Expects a frame whose line bits are given as a '0'/'1' string, each held div clocks,
  // then a single tx_done pulse; 'more' says whether the next frame starts after one idle clock.
  task automatic run_frame(input string tag, input string line, input int div, input bit more);
    int errs, dones, t;
    t = 0;
    while (data_out !== 1'b0 && t < 400) begin
      @(negedge clock);
      t++;
    end
    check({tag, "_start"}, {31'd0, data_out}, 32'd0);
    errs  = 0;
    dones = 0;
    for (int i = 0; i < line.len(); i++) begin
      for (int k = 0; k < div; k++) begin
        if (data_out !== ((line[i] == "1") ? 1'b1 : 1'b0)) errs++;
        if (tx_active !== 1'b1) errs++;
        if (tx_done !== 1'b0) dones++;
        @(negedge clock);
      end
    end
    check({tag, "_bits"}, errs, 0);
    check({tag, "_early_done"}, dones, 0);
    check({tag, "_done"}, {31'd0, tx_done}, 32'd1);
    check({tag, "_active_off"}, {31'd0, tx_active}, 32'd0);
    check({tag, "_idle_line"}, {31'd0, data_out}, 32'd1);
    @(negedge clock);
    check({tag, "_done_1cyc"}, {31'd0, tx_done}, 32'd0);
    check({tag, "_next"}, {31'd0, data_out}, more ? 32'd0 : 32'd1);
  endtask

  initial begin
    int errs, t;
    rst = 1'b0; send = 1'b0; data_in = 8'h00; baud_rate = 2'b00;
    parity_type = 2'b00; stop_bits = 1'b0; data_length = 2'b11;

    // Reset values
    repeat (3) @(negedge clock);
    check("rst_line", {31'd0, data_out}, 32'd1);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_active", {31'd0, tx_active}, 32'd0);
    check("rst_level", {29'd0, fifo_level}, 32'd0);
    rst = 1'b1;

    // Idle hold, no output movement
    errs = 0;
    repeat (20) begin
      @(negedge clock);
      if (data_out !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b0 || overflow !== 1'b0) errs++;
    end
    check("idle_hold", errs, 0);

    // 8N1, 0xA5
    push(8'hA5);
    run_frame("a5", "0101001011", 4, 1'b0);

    // 7 bits, odd parity, 2 stop, 0x41
    data_length = 2'b10; parity_type = 2'b01; stop_bits = 1'b1;
    push(8'h41);
    run_frame("x41_odd", "01000001111", 4, 1'b0);

    // 5 bits, even parity, 1 stop, 0x03
    data_length = 2'b00; parity_type = 2'b10; stop_bits = 1'b0;
    push(8'h03);
    run_frame("x03_even", "01100001", 4, 1'b0);

    // FIFO fill, overflow and ordering
    data_length = 2'b11; parity_type = 2'b00; stop_bits = 1'b0;
    push(8'h10);
    t = 0;
    while (tx_active !== 1'b1 && t < 50) begin
      @(negedge clock);
      t++;
    end
    check("fill_active", {31'd0, tx_active}, 32'd1);
    check("fill_empty", {29'd0, fifo_level}, 32'd0);
    send = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 8'h11 + 8'(i);
      @(negedge clock);
    end
    check("fill_level4", {29'd0, fifo_level}, 32'd4);
    check("fill_ready0", {31'd0, ready}, 32'd0);
    check("fill_no_ovf", {31'd0, overflow}, 32'd0);
    data_in = 8'h15;
    @(negedge clock);
    send = 1'b0;
    check("ovf_pulse", {31'd0, overflow}, 32'd1);
    check("ovf_level", {29'd0, fifo_level}, 32'd4);
    @(negedge clock);
    check("ovf_clear", {31'd0, overflow}, 32'd0);
    t = 0;
    while (tx_done !== 1'b1 && t < 200) begin
      @(negedge clock);
      t++;
    end
    check("x10_done", {31'd0, tx_done}, 32'd1);
    @(negedge clock);
    run_frame("x11", "0100010001", 4, 1'b1);
    run_frame("x12", "0010010001", 4, 1'b1);
    run_frame("x13", "0110010001", 4, 1'b1);
    run_frame("x14", "0001010001", 4, 1'b0);
    check("drained", {29'd0, fifo_level}, 32'd0);

    // Asynchronous reset in the middle of DATA
    push(8'h00);
    push(8'h00);
    t = 0;
    while (data_out !== 1'b0 && t < 50) begin
      @(negedge clock);
      t++;
    end
    repeat (12) @(negedge clock);
    check("pre_rst_line", {31'd0, data_out}, 32'd0);
    check("pre_rst_level", {29'd0, fifo_level}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_line", {31'd0, data_out}, 32'd1);
    check("arst_level", {29'd0, fifo_level}, 32'd0);
    check("arst_active", {31'd0, tx_active}, 32'd0);
    check("arst_ready", {31'd0, ready}, 32'd1);
    repeat (3) @(negedge clock);
    rst = 1'b1;
    errs = 0;
    repeat (30) begin
      @(negedge clock);
      if (tx_done !== 1'b0 || data_out !== 1'b1) errs++;
    end
    check("arst_quiet", errs, 0);

    // Baud change mid-frame takes effect only on the next frame
    push(8'h5A);
    push(8'hC3);
    t = 0;
    while (tx_active !== 1'b1 && t < 50) begin
      @(negedge clock);
      t++;
    end
    baud_rate = 2'b01;
    run_frame("x5a_div4", "0010110101", 4, 1'b1);
    run_frame("xc3_div6", "0110000111", 6, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
